hbm_rdback_packer: RTL and testbench

Single-clock buffer and serializer between the HBM adapter's read-data output (fabric-domain `dfi_0_dw_rddata_p0/p1/valid`) and the readback engine's host-facing stream. It captures every 512-bit read beat into a FIFO and emits it as `512/OUT_W` words over a valid/ready handshake. It also keeps an accepted-beat counter and a sticky overflow flag for host diagnostics.

---
 rtl/hbm_rdback_packer_pkg.sv | 9 +
 rtl/hbm_rdback_packer_if.sv | 36 +++
 rtl/hbm_rdback_packer_fifo.sv | 62 ++++++
 rtl/hbm_rdback_packer.sv | 76 +++++++
 tb/tb_hbm_rdback_packer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/hbm_rdback_packer_pkg.sv
// Shared types and widths for the HBM readback packer.
// Beats are always 512 bits, split as two 256-bit DFI phases.
package hbm_rdback_pkg;
    localparam int BEAT_W = 512;
    localparam int HALF_W = 256;
    localparam int CNT_W  = 32;

    typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/hbm_rdback_packer_if.sv
// Read-beat ingress, word egress and diagnostics of the packer.
// slave is the packer side, master the driving/consuming side.
interface hbm_rdback_packer_if #(
    parameter int DEPTH = 16,
    parameter int OUT_W = 256
);
    import hbm_rdback_pkg::*;

    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [HALF_W-1:0] i_rddata_p0;
    logic [HALF_W-1:0] i_rddata_p1;
    logic              i_rddata_valid;
    logic              i_flush;
    logic              i_ready;
    logic [OUT_W-1:0]  o_data;
    logic              o_valid;
    logic [FILL_W-1:0] o_fill;
    logic              o_empty;
    logic              o_overflow;
    logic [CNT_W-1:0]  o_beat_cnt;

    modport slave (
        input  i_rddata_p0, i_rddata_p1, i_rddata_valid,
        input  i_flush, i_ready,
        output o_data, o_valid, o_fill, o_empty,
        output o_overflow, o_beat_cnt
    );

    modport master (
        output i_rddata_p0, i_rddata_p1, i_rddata_valid,
        output i_flush, i_ready,
        input  o_data, o_valid, o_fill, o_empty,
        input  o_overflow, o_beat_cnt
    );
endinterface

// File: rtl/hbm_rdback_packer_fifo.sv
// DEPTH x 512 synchronous FIFO with combinational head read.
// Fill is tracked apart from the pointers so full and empty are unambiguous.
module rdback_sync_fifo
    import hbm_rdback_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  beat_t                  wdata_i,
    output beat_t                  rdata_o,
    output logic [$clog2(DEPTH):0] fill_o
);
    localparam int PTR_W = $clog2(DEPTH);

    beat_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W:0]     fill_q, fill_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            fill_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
        end
    end

    // Storage needs no reset; fill gates every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign fill_o  = fill_q;
endmodule

// File: rtl/hbm_rdback_packer.sv
// Buffers 512-bit HBM read beats and serialises them into OUT_W words,
// least-significant word first, with beat counter and sticky overflow.
module hbm_rdback_packer
    import hbm_rdback_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OUT_W = 256
) (
    input logic                clk,
    input logic                rst,
    hbm_rdback_packer_if.slave bus
);
    localparam int NW     = BEAT_W / OUT_W;
    localparam int WIDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);
    localparam logic [WIDX_W-1:0] LAST = WIDX_W'(NW - 1);

    beat_t              head;
    logic [FILL_W-1:0]  fill;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               live, valid, hs, pop, push, drop;

    assign live  = bus.i_rddata_valid && !bus.i_flush;
    assign valid = (fill != '0);
    assign hs    = valid && bus.i_ready;
    assign pop   = hs && (widx_q == LAST) && !bus.i_flush;
    assign push  = live && ((fill < FULL) || pop);
    assign drop  = live && !push;

    rdback_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.i_flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.i_rddata_p1, bus.i_rddata_p0}),
        .rdata_o (head),
        .fill_o  (fill)
    );

    always_comb begin
        widx_d = widx_q;
        ovf_d  = ovf_q | drop;
        cnt_d  = cnt_q + CNT_W'(push);
        if (bus.i_flush) begin
            widx_d = '0;
            ovf_d  = 1'b0;
        end else if (hs) begin
            widx_d = (widx_q == LAST) ? '0 : widx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            widx_q <= widx_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.o_data     = valid ? head[int'(widx_q)*OUT_W +: OUT_W] : '0;
    assign bus.o_valid    = valid;
    assign bus.o_fill     = fill;
    assign bus.o_empty    = !valid;
    assign bus.o_overflow = ovf_q;
    assign bus.o_beat_cnt = cnt_q;
endmodule

// File: tb/tb_hbm_rdback_packer.sv
// Directed bench for hbm_rdback_packer: OUT_W=256 and OUT_W=512 instances,
// each checked every cycle against a queue-based model.
module tb_hbm_rdback_packer;
    import hbm_rdback_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]            vld, flush, rdy;
    logic [1:0][255:0]     p0, p1;
    logic [1:0][511:0]     od;
    logic [1:0]            ovd, em, of;
    logic [1:0][4:0]       fl;
    logic [1:0][31:0]      ct;

    int vectors = 0;
    int errs    = 0;

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 256 : 512;
        localparam int NW = 512 / W;
        localparam logic [511:0] WMASK =
            (W == 512) ? {512{1'b1}} : {{256{1'b0}}, {256{1'b1}}};

        hbm_rdback_packer_if #(.DEPTH(DEPTH), .OUT_W(W)) bus ();

        hbm_rdback_packer #(.DEPTH(DEPTH), .OUT_W(W)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.i_rddata_p0    = p0[g];
        assign bus.i_rddata_p1    = p1[g];
        assign bus.i_rddata_valid = vld[g];
        assign bus.i_flush        = flush[g];
        assign bus.i_ready        = rdy[g];
        assign od[g]  = 512'(bus.o_data);
        assign ovd[g] = bus.o_valid;
        assign em[g]  = bus.o_empty;
        assign of[g]  = bus.o_overflow;
        assign fl[g]  = bus.o_fill;
        assign ct[g]  = bus.o_beat_cnt;

        beat_t       q[$];
        int          mw   = 0;
        bit          movf = 0;
        logic [31:0] mcnt = 0;

        always @(posedge clk) begin
            bit pop;
            pop = 0;
            if (rst) begin
                q.delete(); mw = 0; movf = 0; mcnt = 0;
            end else if (flush[g]) begin
                q.delete(); mw = 0; movf = 0;
            end else begin
                if (q.size() != 0 && rdy[g]) begin
                    if (mw == NW - 1) pop = 1;
                    else mw++;
                end
                if (vld[g] && (q.size() < DEPTH || pop)) begin
                    q.push_back({p1[g], p0[g]});
                    mcnt++;
                end else if (vld[g]) begin
                    movf = 1;
                end
                if (pop) begin
                    void'(q.pop_front());
                    mw = 0;
                end
            end
        end

        always @(negedge clk) begin
            logic [511:0] ed;
            bit           ev;
            ev = (q.size() != 0);
            ed = ev ? ((q[0] >> (mw * W)) & WMASK) : '0;
            vectors++;
            if (od[g] !== ed || ovd[g] !== ev || fl[g] !== 5'(q.size()) ||
                em[g] !== !ev || of[g] !== movf || ct[g] !== mcnt) begin
                errs++;
                $display("FAIL model_cfg%0d t=%0t data %h want %h valid %b want %b fill %0d want %0d ovf %b want %b cnt %0d want %0d",
                         g, $time, od[g], ed, ovd[g], ev, fl[g], q.size(),
                         of[g], movf, ct[g], mcnt);
            end
        end
    end

    task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_tags(int n);
        for (int i = 0; i < n; i++) begin
            p0[0] = 256'(i);
            p1[0] = 256'(i + 1000);
            vld[0] = 1'b1;
            @(negedge clk);
        end
        vld[0] = 1'b0;
    endtask

    initial begin
        vld = '0; flush = '0; rdy = 2'b11; p0 = '0; p1 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 512'(ovd[0]), 0);
        chk("rst_empty", 512'(em[0]), 1);
        chk("rst_fill", 512'(fl[0]), 0);
        chk("rst_cnt", 512'(ct[0]), 0);
        chk("rst_ovf", 512'(of[0]), 0);
        chk("rst_data", od[0], 0);
        rst = 1'b0;

        // single beat, word order p0 then p1
        p0[0] = {32{8'h01}};
        p1[0] = {32{8'h02}};
        vld[0] = 1'b1;
        chk("t1_pre_valid", 512'(ovd[0]), 0);
        @(negedge clk);
        vld[0] = 1'b0;
        chk("t1_valid", 512'(ovd[0]), 1);
        chk("t1_w0", od[0], {256'b0, {32{8'h01}}});
        @(negedge clk);
        chk("t1_w1", od[0], {256'b0, {32{8'h02}}});
        @(negedge clk);
        chk("t1_fill", 512'(fl[0]), 0);
        chk("t1_cnt", 512'(ct[0]), 1);

        // 17 beats into a stalled 16-deep FIFO
        do_rst();
        rdy[0] = 1'b0;
        push_tags(17);
        chk("t2_fill", 512'(fl[0]), 16);
        chk("t2_ovf", 512'(of[0]), 1);
        chk("t2_cnt", 512'(ct[0]), 16);
        rdy[0] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            chk("t2_tag", od[0], 512'(t));
            repeat (2) @(negedge clk);
        end
        chk("t2_drained", 512'(fl[0]), 0);

        // full FIFO, pop and push on the same edge
        do_rst();
        rdy[0] = 1'b0;
        push_tags(16);
        chk("t3_full", 512'(fl[0]), 16);
        rdy[0] = 1'b1;
        @(negedge clk);
        p0[0] = 256'(99);
        p1[0] = 256'(1099);
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        rdy[0] = 1'b0;
        chk("t3_fill", 512'(fl[0]), 16);
        chk("t3_ovf", 512'(of[0]), 0);
        chk("t3_cnt", 512'(ct[0]), 17);
        chk("t3_head", od[0], 512'(1));

        // stall mid-beat for 5 cycles
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold", od[0], 512'(1001));
            @(negedge clk);
        end
        chk("t4_hold_end", od[0], 512'(1001));
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("t4_next_w0", od[0], 512'(2));
        @(negedge clk);
        chk("t4_next_w1", od[0], 512'(1002));
        rdy[0] = 1'b0;

        // flush with a concurrent beat
        do_rst();
        rdy[0] = 1'b0;
        push_tags(17);
        rdy[0] = 1'b1;
        repeat (26) @(negedge clk);
        rdy[0] = 1'b0;
        chk("t5_fill3", 512'(fl[0]), 3);
        chk("t5_ovf_set", 512'(of[0]), 1);
        p0[0] = 256'(77);
        vld[0] = 1'b1;
        flush[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        flush[0] = 1'b0;
        chk("t5_fill", 512'(fl[0]), 0);
        chk("t5_valid", 512'(ovd[0]), 0);
        chk("t5_ovf", 512'(of[0]), 0);
        chk("t5_cnt", 512'(ct[0]), 16);
        chk("t5_data", od[0], 0);

        // OUT_W=512 back-to-back
        do_rst();
        for (int i = 0; i < 64; i++) begin
            p0[1] = 256'(i);
            p1[1] = ~256'(i);
            vld[1] = 1'b1;
            @(negedge clk);
            chk("t6_word", od[1], {~256'(i), 256'(i)});
        end
        vld[1] = 1'b0;
        @(negedge clk);
        chk("t6_cnt", 512'(ct[1]), 64);
        chk("t6_ovf", 512'(of[1]), 0);
        chk("t6_fill", 512'(fl[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
